// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter with a per-register pending-write scoreboard.
// Writes are registered one cycle after the accepting handshake. Writes to register 0 are dropped.
module regfile_wr_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req0_valid_i,
  input  logic [2:0] req0_addr_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [2:0] req1_addr_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  input  logic       mark_valid_i,
  input  logic [2:0] mark_addr_i,
  output logic       wr_en_o,
  output logic [2:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] busy_o,
  output logic       err_o
);

  logic       gnt0, gnt1, xfer, mark_hit;
  logic [2:0] win_addr;
  logic [7:0] win_data;

  logic       last_grant_q, last_grant_d;
  logic       wr_en_q, wr_en_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] busy_q, busy_d;
  logic       err_q, err_d;

  always_comb begin
    // last_grant_q == 1 means requester 1 won most recently, so requester 0 is next.
    gnt0     = req0_valid_i && (!req1_valid_i || (FIXED_PRIO != 0) || last_grant_q);
    gnt1     = req1_valid_i && !gnt0;
    xfer     = gnt0 || gnt1;
    win_addr = gnt0 ? req0_addr_i : req1_addr_i;
    win_data = gnt0 ? req0_data_i : req1_data_i;

    last_grant_d = xfer ? gnt1 : last_grant_q;
    wr_en_d      = xfer && (win_addr != 3'd0);
    wr_addr_d    = xfer ? win_addr : wr_addr_q;
    wr_data_d    = xfer ? win_data : wr_data_q;

    // A mark only errors if the register stays busy, i.e. is not committed on this same edge.
    mark_hit = mark_valid_i && (mark_addr_i != 3'd0) && busy_q[mark_addr_i] &&
               !(wr_en_q && (wr_addr_q == mark_addr_i));
    err_d    = err_q || mark_hit;

    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (mark_valid_i && (mark_addr_i != 3'd0)) busy_d[mark_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 3'd0;
      wr_data_q    <= 8'h00;
      busy_q       <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share all inputs.
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
module tb_regfile_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, mark_valid;
  logic [2:0] req0_addr, req1_addr, mark_addr;
  logic [7:0] req0_data, req1_data;

  logic       rr_ready0, rr_ready1, rr_wr_en, rr_err;
  logic [2:0] rr_wr_addr;
  logic [7:0] rr_wr_data, rr_busy;
  logic       fp_ready0, fp_ready1, fp_wr_en, fp_err;
  logic [2:0] fp_wr_addr;
  logic [7:0] fp_wr_data, fp_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_data_i(req0_data),
    .req0_ready_o(rr_ready0),
    .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_data_i(req1_data),
    .req1_ready_o(rr_ready1),
    .mark_valid_i(mark_valid), .mark_addr_i(mark_addr),
    .wr_en_o(rr_wr_en), .wr_addr_o(rr_wr_addr), .wr_data_o(rr_wr_data),
    .busy_o(rr_busy), .err_o(rr_err)
  );

  regfile_wr_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_data_i(req0_data),
    .req0_ready_o(fp_ready0),
    .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_data_i(req1_data),
    .req1_ready_o(fp_ready1),
    .mark_valid_i(mark_valid), .mark_addr_i(mark_addr),
    .wr_en_o(fp_wr_en), .wr_addr_o(fp_wr_addr), .wr_data_o(fp_wr_data),
    .busy_o(fp_busy), .err_o(fp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = 3'd0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 8'h00;
    mark_valid = 1'b0; mark_addr = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check_eq("rst_wr_en", {31'd0, rr_wr_en}, 32'd0);
    check_eq("rst_wr_addr", {29'd0, rr_wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'd0, rr_wr_data}, 32'h00);
    check_eq("rst_busy", {24'd0, rr_busy}, 32'h00);
    check_eq("rst_err", {31'd0, rr_err}, 32'd0);
    check_eq("rst_ready_idle", {30'd0, rr_ready1, rr_ready0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0 write.
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 8'h5A;
    #1;
    check_eq("solo_ready", {30'd0, rr_ready1, rr_ready0}, 32'b01);
    tick();
    check_eq("solo_wr_en", {31'd0, rr_wr_en}, 32'd1);
    check_eq("solo_wr_addr", {29'd0, rr_wr_addr}, 32'd3);
    check_eq("solo_wr_data", {24'd0, rr_wr_data}, 32'h5A);
    @(negedge clk);
    req0_valid = 1'b0;
    tick();
    check_eq("solo_wr_en_drop", {31'd0, rr_wr_en}, 32'd0);
    check_eq("solo_addr_hold", {29'd0, rr_wr_addr}, 32'd3);
    check_eq("solo_data_hold", {24'd0, rr_wr_data}, 32'h5A);

    // Contention: round-robin alternates from requester 0, fixed priority always picks 0.
    do_reset();
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rr_grant%0d", i), {30'd0, rr_ready1, rr_ready0},
               (i % 2 == 0) ? 32'b01 : 32'b10);
      if (i < 3) check_eq($sformatf("fp_grant%0d", i), {30'd0, fp_ready1, fp_ready0}, 32'b01);
      tick();
      check_eq($sformatf("rr_wr_addr%0d", i), {28'd0, rr_wr_en, rr_wr_addr},
               (i % 2 == 0) ? 32'h9 : 32'hA);
      check_eq($sformatf("rr_wr_data%0d", i), {24'd0, rr_wr_data},
               (i % 2 == 0) ? 32'h11 : 32'h22);
      @(negedge clk);
    end
    check_eq("fp_wr_addr", {28'd0, fp_wr_en, fp_wr_addr}, 32'h9);
    idle_inputs();

    // Scoreboard: mark, commit clears, commit to idle register, commit racing a re-mark.
    do_reset();
    mark_valid = 1'b1; mark_addr = 3'd5;
    tick();
    check_eq("sb_mark5", {24'd0, rr_busy}, 32'h20);
    @(negedge clk);
    mark_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h77;
    #1;
    check_eq("sb_req1_ready", {30'd0, rr_ready1, rr_ready0}, 32'b10);
    tick();
    check_eq("sb_wr_cycle", {23'd0, rr_wr_en, rr_busy}, 32'h120);
    @(negedge clk);
    req1_valid = 1'b0;
    tick();
    check_eq("sb_cleared", {24'd0, rr_busy}, 32'h00);
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 8'h66;
    mark_valid = 1'b1; mark_addr = 3'd5;
    tick();
    check_eq("sb_remark5", {24'd0, rr_busy}, 32'h20);
    @(negedge clk);
    req0_valid = 1'b0; mark_valid = 1'b0;
    tick();
    check_eq("sb_idle_commit", {23'd0, rr_err, rr_busy}, 32'h020);
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h78;
    tick();
    @(negedge clk);
    req1_valid = 1'b0;
    mark_valid = 1'b1; mark_addr = 3'd5;
    tick();
    check_eq("sb_race_busy", {24'd0, rr_busy}, 32'h20);
    check_eq("sb_race_err", {31'd0, rr_err}, 32'd0);
    @(negedge clk);
    mark_valid = 1'b0;

    // Address 0 writes are accepted but dropped; double mark sets a sticky error.
    do_reset();
    req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 8'h99;
    mark_valid = 1'b1; mark_addr = 3'd0;
    #1;
    check_eq("a0_ready", {31'd0, rr_ready0}, 32'd1);
    tick();
    check_eq("a0_wr_en", {31'd0, rr_wr_en}, 32'd0);
    check_eq("a0_mark_busy", {24'd0, rr_busy}, 32'h00);
    @(negedge clk);
    req0_valid = 1'b0;
    mark_addr = 3'd4;
    tick();
    check_eq("a0_busy_unchanged", {23'd0, rr_err, rr_busy}, 32'h010);
    tick();
    check_eq("dbl_mark_err", {23'd0, rr_err, rr_busy}, 32'h110);
    @(negedge clk);
    mark_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("err_sticky", {31'd0, rr_err}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("err_async_clear", {31'd0, rr_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset landing on a live transfer, then requester 0 wins the first contention.
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 8'h33;
    mark_valid = 1'b1; mark_addr = 3'd2;
    tick();
    check_eq("mid_pre_state", {23'd0, rr_wr_en, rr_busy}, 32'h104);
    @(negedge clk);
    mark_valid = 1'b0;
    req0_addr = 3'd4; req0_data = 8'h44;
    #1;
    check_eq("mid_ready", {31'd0, rr_ready0}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async", {20'd0, rr_wr_en, rr_wr_addr, rr_busy}, 32'h000);
    tick();
    check_eq("mid_discard", {31'd0, rr_wr_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h55;
    #1;
    check_eq("post_rst_grant", {30'd0, rr_ready1, rr_ready0}, 32'b01);
    tick();
    check_eq("post_rst_write", {20'd0, rr_wr_en, rr_wr_addr, rr_wr_data}, 32'hC44);
    @(negedge clk);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
